// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns 7-byte host frames (AA ADDR D3 D2 D1 D0 CHK) into DDS register writes plus an ACK/NAK byte.
// Latency: CHK byte strobed in cycle N -> reg_wr/err_chk/tx_en pulse in cycle N+1; reg_addr/reg_wdata valid from N+1.
// Backpressure: none; every rx_done byte is consumed, and a partial frame is dropped after a TIMEOUT_BYTES idle gap.
module uart_cmd_decoder #(
  parameter int FREQ          = 50000000,
  parameter int BPS           = 9600,
  parameter int TIMEOUT_BYTES = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  uart_data,
  input  logic        rx_done,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        err_chk,
  output logic        err_timeout
);

  // One byte time is 10 bit times (start + 8 data + stop).
  localparam int               TIMEOUT_CYC = (FREQ / BPS) * 10 * TIMEOUT_BYTES;
  localparam int               CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_TERM    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  localparam logic [7:0] SOF_BYTE = 8'hAA;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_D3   = 3'd2,
    S_D2   = 3'd3,
    S_D1   = 3'd4,
    S_D0   = 3'd5,
    S_CHK  = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  // Shadow copy of the frame being received; only promoted to the outputs on a good checksum.
  logic [7:0]        r_addr_s;
  logic [7:0]        w_addr_s_nxt;
  logic [31:0]       r_data_s;
  logic [31:0]       w_data_s_nxt;
  logic [7:0]        r_xor;
  logic [7:0]        w_xor_nxt;

  logic              r_reg_wr;
  logic              w_reg_wr_nxt;
  logic [7:0]        r_reg_addr;
  logic [7:0]        w_reg_addr_nxt;
  logic [31:0]       r_reg_wdata;
  logic [31:0]       w_reg_wdata_nxt;
  logic [7:0]        r_tx_data;
  logic [7:0]        w_tx_data_nxt;
  logic              r_tx_en;
  logic              w_tx_en_nxt;
  logic              r_err_chk;
  logic              w_err_chk_nxt;
  logic              r_err_timeout;
  logic              w_err_timeout_nxt;

  // A byte landing on the terminal count wins over the timeout.
  logic              w_expire;
  assign w_expire = (r_state != S_IDLE) && (r_cnt == CNT_TERM) && !rx_done;

  assign reg_wr      = r_reg_wr;
  assign reg_addr    = r_reg_addr;
  assign reg_wdata   = r_reg_wdata;
  assign tx_data     = r_tx_data;
  assign tx_en       = r_tx_en;
  assign err_chk     = r_err_chk;
  assign err_timeout = r_err_timeout;

  // Frame state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, shadow capture, running checksum, gap counter and output strobes.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_addr_s_nxt      = r_addr_s;
    w_data_s_nxt      = r_data_s;
    w_xor_nxt         = r_xor;
    w_reg_addr_nxt    = r_reg_addr;
    w_reg_wdata_nxt   = r_reg_wdata;
    w_tx_data_nxt     = r_tx_data;
    w_reg_wr_nxt      = 1'b0;
    w_tx_en_nxt       = 1'b0;
    w_err_chk_nxt     = 1'b0;
    w_err_timeout_nxt = 1'b0;

    // Gap counter only runs while a frame is open; the expiry itself returns us to IDLE.
    if (rx_done || (r_state == S_IDLE) || w_expire) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end

    if (rx_done) begin
      case (r_state)
        S_IDLE: begin
          if (uart_data == SOF_BYTE) begin
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR: begin
          w_addr_s_nxt = uart_data;
          w_xor_nxt    = uart_data;
          w_state_nxt  = S_D3;
        end
        S_D3: begin
          w_data_s_nxt = {r_data_s[23:0], uart_data};
          w_xor_nxt    = r_xor ^ uart_data;
          w_state_nxt  = S_D2;
        end
        S_D2: begin
          w_data_s_nxt = {r_data_s[23:0], uart_data};
          w_xor_nxt    = r_xor ^ uart_data;
          w_state_nxt  = S_D1;
        end
        S_D1: begin
          w_data_s_nxt = {r_data_s[23:0], uart_data};
          w_xor_nxt    = r_xor ^ uart_data;
          w_state_nxt  = S_D0;
        end
        S_D0: begin
          w_data_s_nxt = {r_data_s[23:0], uart_data};
          w_xor_nxt    = r_xor ^ uart_data;
          w_state_nxt  = S_CHK;
        end
        S_CHK: begin
          w_tx_en_nxt = 1'b1;
          if (uart_data == r_xor) begin
            w_reg_addr_nxt  = r_addr_s;
            w_reg_wdata_nxt = r_data_s;
            w_reg_wr_nxt    = 1'b1;
            w_tx_data_nxt   = ACK_BYTE;
          end else begin
            w_err_chk_nxt   = 1'b1;
            w_tx_data_nxt   = NAK_BYTE;
          end
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end else if (w_expire) begin
      w_err_timeout_nxt = 1'b1;
      w_state_nxt       = S_IDLE;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt         <= '0;
      r_addr_s      <= '0;
      r_data_s      <= '0;
      r_xor         <= '0;
      r_reg_wr      <= 1'b0;
      r_reg_addr    <= '0;
      r_reg_wdata   <= '0;
      r_tx_data     <= '0;
      r_tx_en       <= 1'b0;
      r_err_chk     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_addr_s      <= w_addr_s_nxt;
      r_data_s      <= w_data_s_nxt;
      r_xor         <= w_xor_nxt;
      r_reg_wr      <= w_reg_wr_nxt;
      r_reg_addr    <= w_reg_addr_nxt;
      r_reg_wdata   <= w_reg_wdata_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_tx_en       <= w_tx_en_nxt;
      r_err_chk     <= w_err_chk_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: drives byte streams into uart_cmd_decoder and checks strobes against a frame-level model.
// Latency: expects decode strobes one cycle after the CHK byte and timeout strobes TIMEOUT_CYC cycles after the last byte.
// Backpressure: none; bytes are pushed whenever the stimulus chooses.
module tb_uart_cmd_decoder;

  localparam int FREQ   = 1000;
  localparam int BPS    = 100;
  localparam int TBYTES = 3;
  localparam int TO     = (FREQ / BPS) * 10 * TBYTES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  uart_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        err_chk;
  logic        err_timeout;

  uart_cmd_decoder #(.FREQ(FREQ), .BPS(BPS), .TIMEOUT_BYTES(TBYTES)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .uart_data   (uart_data),
    .rx_done     (rx_done),
    .reg_wr      (reg_wr),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .err_chk     (err_chk),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // st = {reg_wr, err_chk, err_timeout, tx_en}
  typedef struct packed {
    int          cyc;
    logic [3:0]  st;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  txd;
  } ev_t;

  ev_t act_q[$];
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Observed strobe events, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (reg_wr | err_chk | err_timeout | tx_en) !== 1'b0)
      act_q.push_back('{cyc, {reg_wr, err_chk, err_timeout, tx_en}, reg_addr, reg_wdata, tx_data});
  end

  // Reference model: bytes of the currently open frame, plus last committed values.
  logic [7:0]  frame_q[$];
  int          last_e = 0;
  logic [7:0]  m_addr = 8'h00;
  logic [31:0] m_data = 32'h0;
  logic [7:0]  m_txd  = 8'h00;

  task automatic model_byte(input logic [7:0] b, input int e);
    logic [7:0] x;
    if (frame_q.size() > 0 && (e - last_e) > TO) begin
      exp_q.push_back('{last_e + TO, 4'b0010, m_addr, m_data, m_txd});
      frame_q.delete();
    end
    last_e = e;
    if (frame_q.size() == 0) begin
      if (b == 8'hAA) frame_q.push_back(b);
    end else begin
      frame_q.push_back(b);
      if (frame_q.size() == 7) begin
        x = frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4] ^ frame_q[5];
        if (x == frame_q[6]) begin
          m_addr = frame_q[1];
          m_data = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
          m_txd  = 8'h06;
          exp_q.push_back('{e, 4'b1001, m_addr, m_data, m_txd});
        end else begin
          m_txd = 8'h15;
          exp_q.push_back('{e, 4'b0101, m_addr, m_data, m_txd});
        end
        frame_q.delete();
      end
    end
  endtask

  task automatic model_flush();
    if (frame_q.size() > 0 && cyc >= last_e + TO) begin
      exp_q.push_back('{last_e + TO, 4'b0010, m_addr, m_data, m_txd});
      frame_q.delete();
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_addr = 8'h00;
    m_data = 32'h0;
    m_txd  = 8'h00;
  endtask

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    uart_data = b;
    rx_done   = 1'b1;
    @(posedge clk);
    #1;
    rx_done   = 1'b0;
    uart_data = 8'($urandom);
    model_byte(b, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] flip, input int maxgap);
    logic [7:0] bs [7];
    bs[0] = 8'hAA;
    bs[1] = a;
    bs[2] = d[31:24];
    bs[3] = d[23:16];
    bs[4] = d[15:8];
    bs[5] = d[7:0];
    bs[6] = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ flip;
    for (int i = 0; i < 7; i++) begin
      send(bs[i]);
      if (i < 6) idle(int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic quiesce();
    idle(TO + 2);
    model_flush();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rx_done   = 1'b1;
    uart_data = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({reg_wr, tx_en, err_chk, err_timeout} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want 0000", {reg_wr, tx_en, err_chk, err_timeout});
    end
    n_cmp++;
    if (reg_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_reg_addr got %h want 00", reg_addr);
    end
    n_cmp++;
    if (reg_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_reg_wdata got %h want 00000000", reg_wdata);
    end
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_tx_data got %h want 00", tx_data);
    end
    rx_done = 1'b0;
    rst_n   = 1'b1;
    idle(3);
    n_cmp++;
    if (act_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_release_events got %0d want 0", act_q.size());
    end
    act_q.delete();
  endtask

  task automatic test_good_frame();
    send_frame(8'h01, 32'h12345678, 8'h00, 3);
    idle(2);
    n_cmp++;
    if (reg_addr !== 8'h01 || reg_wdata !== 32'h12345678 || tx_data !== 8'h06) begin
      n_bad++;
      $display("FAIL good_frame_regs got a=%h d=%h tx=%h want a=01 d=12345678 tx=06", reg_addr, reg_wdata, tx_data);
    end
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL good_frame_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL good_frame_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_bad_chk();
    // CHK 0x0A instead of the correct 0x09.
    send_frame(8'h01, 32'h12345678, 8'h03, 2);
    idle(2);
    n_cmp++;
    if (reg_addr !== 8'h01 || reg_wdata !== 32'h12345678 || tx_data !== 8'h15) begin
      n_bad++;
      $display("FAIL bad_chk_regs got a=%h d=%h tx=%h want a=01 d=12345678 tx=15", reg_addr, reg_wdata, tx_data);
    end
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL bad_chk_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bad_chk_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_junk();
    send(8'h00);
    idle(1);
    send(8'hFF);
    idle(4);
    send(8'h55);
    idle(3);
    n_cmp++;
    if (act_q.size() != 0) begin
      n_bad++;
      $display("FAIL junk_silent got %0d events want 0", act_q.size());
    end
    send_frame(8'h02, 32'h00000001, 8'h00, 2);
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL junk_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL junk_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    send(8'hAA);
    send(8'h03);
    idle(2);
    send(8'h11);
    idle(TO + 2);
    model_flush();
    send_frame(8'h09, 32'hCAFEF00D, 8'h00, 4);
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL timeout_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL timeout_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_boundary();
    // 0xAA inside a frame is data: AA 04 AA AA AA AA 04.
    send_frame(8'h04, 32'hAAAAAAAA, 8'h00, 1);
    idle(2);
    n_cmp++;
    if (reg_wdata !== 32'hAAAAAAAA || reg_addr !== 8'h04) begin
      n_bad++;
      $display("FAIL aa_data_regs got a=%h d=%h want a=04 d=aaaaaaaa", reg_addr, reg_wdata);
    end
    // Next byte exactly TO cycles after the previous one: accepted.
    send(8'hAA);
    send(8'h0B);
    idle(TO - 1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    send(8'h0B ^ 8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04);
    idle(3);
    // One cycle later than that: timeout, and the late byte is dropped in idle.
    send(8'hAA);
    send(8'h08);
    idle(TO);
    send(8'h33);
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL boundary_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL boundary_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send(8'hAA);
    send(8'h05);
    send(8'h12);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_wr, tx_en, err_chk, err_timeout} !== 4'b0000 || reg_addr !== 8'h00 ||
        reg_wdata !== 32'h0 || tx_data !== 8'h00) begin
      n_bad++;
      $display("FAIL midframe_reset got st=%b a=%h d=%h tx=%h want all zero",
               {reg_wr, tx_en, err_chk, err_timeout}, reg_addr, reg_wdata, tx_data);
    end
    idle(3);
    rst_n = 1'b1;
    model_reset();
    idle(2);
    // Second frame's SOF lands in the cycle right after the first frame's ACK.
    send_frame(8'h06, 32'h0BADBEEF, 8'h00, 2);
    send_frame(8'h07, 32'h00C0FFEE, 8'h00, 0);
    idle(2);
    n_cmp++;
    if (reg_addr !== 8'h07 || reg_wdata !== 32'h00C0FFEE) begin
      n_bad++;
      $display("FAIL b2b_regs got a=%h d=%h want a=07 d=00c0ffee", reg_addr, reg_wdata);
    end
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL b2b_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    int sel;
    int n;
    for (int k = 0; k < 30; k++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 1) begin
        send(8'($urandom));
      end else if (sel <= 6) begin
        send_frame(8'($urandom), $urandom, 8'h00, (sel == 6) ? TO - 1 : 4);
      end else if (sel <= 8) begin
        send_frame(8'($urandom), $urandom, 8'($urandom_range(1, 255)), 4);
      end else begin
        send(8'hAA);
        n = int'($urandom_range(1, 5));
        for (int j = 0; j < n; j++) send(8'($urandom));
        idle(TO + int'($urandom_range(0, 3)));
      end
      idle(int'($urandom_range(0, 6)));
    end
    quiesce();
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random_count got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_cmp++;
      if (act_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random_ev%0d got cyc=%0d st=%b a=%h d=%h tx=%h want cyc=%0d st=%b a=%h d=%h tx=%h", i,
                 act_q[i].cyc, act_q[i].st, act_q[i].addr, act_q[i].data, act_q[i].txd,
                 exp_q[i].cyc, exp_q[i].st, exp_q[i].addr, exp_q[i].data, exp_q[i].txd);
      end
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_junk();
    test_timeout();
    test_boundary();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
